// File: rtl/bus_initiator.sv
// bus_initiator: initiator side of the native parallel bus.
// Takes one request at a time on a valid/ready handshake, drives
// addr/wdata through setup, strobe and hold phases, then pulses rsp_valid.
//
// state  | meaning
// IDLE   | ready for a request; addr/wdata keep their last values
// SETUP  | addr/wdata stable, r_wn high, waiting before the strobe
// STROBE | r_wn low for writes, high for reads; reads sample rdata on the last edge
// HOLD   | addr/wdata stable after the strobe; rsp_valid follows on the final edge
module bus_initiator #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_r_wn,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  r_wn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam int MAX_SP = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_PH = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_PH) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_read_q, op_read_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    r_wn_q, r_wn_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic cnt_zero;

    assign accept   = (state_q == IDLE) && req_valid;
    assign cnt_zero = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each phase advances when its counter reaches zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SETUP;
            SETUP:   if (cnt_zero) state_d = STROBE;
            STROBE:  if (cnt_zero) state_d = HOLD;
            HOLD:    if (cnt_zero) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output/datapath next values: phase counter, bus latches, read capture, response pulse
    always_comb begin
        cnt_d       = cnt_q;
        op_read_d   = op_read_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    op_read_d = req_r_wn;
                    cnt_d     = SETUP_LOAD;
                end
            end
            SETUP: begin
                cnt_d = cnt_zero ? STROBE_LOAD : (cnt_q - CNT_ONE);
            end
            STROBE: begin
                if (cnt_zero) begin
                    cnt_d = HOLD_LOAD;
                    if (op_read_q) begin
                        rsp_rdata_d = rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                cnt_d = cnt_zero ? '0 : (cnt_q - CNT_ONE);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // r_wn is registered from the next state so it never glitches on the bus
        r_wn_d      = !((state_d == STROBE) && !op_read_q);
        rsp_valid_d = (state_q == HOLD) && cnt_zero;
    end

    // Datapath and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_read_q   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            r_wn_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            op_read_q   <= op_read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            r_wn_q      <= r_wn_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign r_wn      = r_wn_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule
